// File: rtl/aixh_mxc_bias_align_pkg.sv
// -----------------------------------------------------------------------------
// aixh_mxc_bias_align_pkg
// Shared constants and types for the MxConv corner bias-alignment path.
//   BIAS_SHIFT_STEP : bit distance between successive i_mac_shift codes
//   DEF_*           : default channel / field / table sizes
//   chan_t          : one drain channel {scale, bias} at default widths
//   acc_ctl_t       : accumulator control bundle at default widths
// -----------------------------------------------------------------------------
package aixh_mxc_bias_align_pkg;

  localparam int BIAS_SHIFT_STEP = 8;

  localparam int DEF_CH     = 4;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_SC_W   = 16;
  localparam int DEF_MODES  = 8;
  localparam int DEF_MODE_W = $clog2(DEF_MODES);

  typedef struct packed {
    logic [DEF_SC_W-1:0]  scale;
    logic [DEF_ACC_W-1:0] bias;
  } chan_t;

  typedef struct packed {
    logic                  afresh;
    logic                  enable;
    logic [DEF_MODE_W-1:0] mode;
    logic [1:0]            shift;
    logic                  drain_req;
  } acc_ctl_t;

endpackage

// File: rtl/aixh_mxc_bias_align_snap_fifo.sv
// -----------------------------------------------------------------------------
// aixh_mxc_snap_fifo
// Small snapshot queue for accumulated bias offsets.
//   aixh_core_clk2x / aixh_core_rstn : clock, synchronous active-low reset
//   i_push, i_push_data              : enqueue a snapshot
//   i_pop                            : dequeue head (ignored when empty)
//   i_rd                             : head is being consumed this cycle
//   o_head                           : head snapshot, 0 when empty
//   o_cnt                            : occupancy after the current edge
//   o_ovf, o_unf                     : sticky overflow / underflow
// -----------------------------------------------------------------------------
module aixh_mxc_snap_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                       aixh_core_clk2x,
  input  logic                       aixh_core_rstn,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  input  logic                       i_rd,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_ovf,
  output logic                       o_unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can proceed.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge aixh_core_clk2x) begin
    if (!aixh_core_rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && w_full && !w_do_pop) begin
        r_ovf <= 1'b1;
      end
      if (i_rd && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign o_head = w_empty ? '0 : r_mem[r_rd];
  assign o_cnt  = r_cnt;
  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;

endmodule

// File: rtl/aixh_mxc_bias_align.sv
// -----------------------------------------------------------------------------
// aixh_mxc_bias_align
// Accumulates a per-mode MAC bias offset, snapshots it on drain requests,
// adds the matching snapshot to every channel's bias of drained upper-tile
// data and delays the result by a programmable depth toward the left tile.
//   aixh_core_clk2x / aixh_core_rstn        : clock, synchronous active-low reset
//   i_cfg_we/addr/wdata                     : bias-table write port
//   i_cfg_delay                             : alignment delay (clamped 1..MAX_PIPES)
//   i_mac_afresh/enable/mode/shift          : accumulator control
//   i_drain_req                             : push current accumulator snapshot
//   i_vld/i_last/i_dat                      : drain beats in
//   o_vld/o_last/o_dat                      : aligned, bias-adjusted beats out
//   o_snap_cnt, o_ovf, o_unf                : queue occupancy and sticky flags
// -----------------------------------------------------------------------------
module aixh_mxc_bias_align
  import aixh_mxc_bias_align_pkg::*;
#(
  parameter int CH         = DEF_CH,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int SC_W       = DEF_SC_W,
  parameter int MODES      = DEF_MODES,
  parameter int MAX_PIPES  = 8,
  parameter int SNAP_DEPTH = 4
) (
  input  logic                                aixh_core_clk2x,
  input  logic                                aixh_core_rstn,
  input  logic                                i_cfg_we,
  input  logic [$clog2(MODES)-1:0]            i_cfg_addr,
  input  logic [ACC_W-1:0]                    i_cfg_wdata,
  input  logic [$clog2(MAX_PIPES+1)-1:0]      i_cfg_delay,
  input  logic                                i_mac_afresh,
  input  logic                                i_mac_enable,
  input  logic [$clog2(MODES)-1:0]            i_mac_mode,
  input  logic [1:0]                          i_mac_shift,
  input  logic                                i_drain_req,
  input  logic                                i_vld,
  input  logic                                i_last,
  input  logic [CH*(SC_W+ACC_W)-1:0]          i_dat,
  output logic                                o_vld,
  output logic                                o_last,
  output logic [CH*(SC_W+ACC_W)-1:0]          o_dat,
  output logic [$clog2(SNAP_DEPTH+1)-1:0]     o_snap_cnt,
  output logic                                o_ovf,
  output logic                                o_unf
);

  localparam int CH_W  = SC_W + ACC_W;
  localparam int DAT_W = CH * CH_W;
  localparam int DLY_W = $clog2(MAX_PIPES+1);
  localparam int TAP_W = $clog2(MAX_PIPES);
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_PIPES);

  acc_ctl_t         w_ctl;
  logic [ACC_W-1:0] r_table [MODES];
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_head;
  logic [DAT_W-1:0] w_adj;
  logic [DLY_W-1:0] w_deff;
  logic [TAP_W-1:0] w_tap;

  logic [MAX_PIPES-1:0] r_vld;
  logic [MAX_PIPES-1:0] r_last;
  logic [DAT_W-1:0]     r_dat [MAX_PIPES];

  assign w_ctl = '{afresh:    i_mac_afresh,
                   enable:    i_mac_enable,
                   mode:      i_mac_mode,
                   shift:     i_mac_shift,
                   drain_req: i_drain_req};

  // Table read is from the registered array, so a same-cycle write to the
  // selected entry is seen only from the next cycle on.
  assign w_addend = r_table[w_ctl.mode] << (BIAS_SHIFT_STEP * w_ctl.shift);

  always_ff @(posedge aixh_core_clk2x) begin
    if (!aixh_core_rstn) begin
      r_acc <= '0;
      for (int m = 0; m < MODES; m++) begin
        r_table[m] <= '0;
      end
    end else begin
      if (i_cfg_we) begin
        r_table[i_cfg_addr] <= i_cfg_wdata;
      end
      if (w_ctl.afresh) begin
        r_acc <= ACC_W'(1);
      end else if (w_ctl.enable) begin
        r_acc <= r_acc + w_addend;
      end
    end
  end

  aixh_mxc_snap_fifo #(
    .DEPTH (SNAP_DEPTH),
    .W     (ACC_W)
  ) u_snap_fifo (
    .aixh_core_clk2x (aixh_core_clk2x),
    .aixh_core_rstn  (aixh_core_rstn),
    .i_push          (w_ctl.drain_req),
    .i_push_data     (r_acc),
    .i_pop           (i_vld & i_last),
    .i_rd            (i_vld),
    .o_head          (w_head),
    .o_cnt           (o_snap_cnt),
    .o_ovf           (o_ovf),
    .o_unf           (o_unf)
  );

  always_comb begin
    w_adj = i_dat;
    for (int c = 0; c < CH; c++) begin
      w_adj[c*CH_W +: ACC_W] = i_dat[c*CH_W +: ACC_W] + w_head;
    end
  end

  always_comb begin
    w_deff = i_cfg_delay;
    if (i_cfg_delay == '0) begin
      w_deff = DLY_W'(1);
    end else if (i_cfg_delay > MAX_D) begin
      w_deff = MAX_D;
    end
  end

  // Stage k (0-based) holds a beat k+1 cycles after it arrived.
  assign w_tap = TAP_W'(w_deff - DLY_W'(1));

  always_ff @(posedge aixh_core_clk2x) begin
    if (!aixh_core_rstn) begin
      r_vld  <= '0;
      r_last <= '0;
      for (int k = 0; k < MAX_PIPES; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_vld  <= {r_vld[MAX_PIPES-2:0], i_vld};
      r_last <= {r_last[MAX_PIPES-2:0], i_vld & i_last};
      if (i_vld) begin
        r_dat[0] <= w_adj;
      end
      for (int k = 1; k < MAX_PIPES; k++) begin
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[w_tap];
  assign o_last = r_last[w_tap];
  assign o_dat  = r_dat[w_tap];

endmodule

// File: doc/aixh_mxc_bias_align.md
Name: aixh_mxc_bias_align

Overview:
- Parametrised successor of the MxConv corner bias path.
- Accumulates a programmable per-mode MAC bias offset while the upper tile computes.
- Snapshots the accumulated offset on each drain request into a small queue, so several drains can be outstanding.
- Adds the matching snapshot to every channel of drained upper-tile data, then delays the result by a runtime-programmable depth so it aligns with inner-tile drain latency before it goes to the left tile.

Parameters:
- CH, 4, number of parallel drain channels per beat
- ACC_W, 48, accumulator/bias field width
- SC_W, 16, scale field width per channel
- MODES, 8, number of bias-table entries (mac_mode values)
- MAX_PIPES, 8, maximum alignment delay in cycles
- SNAP_DEPTH, 4, snapshot queue depth (power of 2, at least 2)

Ports:
- aixh_core_clk2x  in  1  sole clock
- aixh_core_rstn  in  1  synchronous active-low reset
- i_cfg_we  in  1  bias-table write strobe
- i_cfg_addr  in  $clog2(MODES)  bias-table index
- i_cfg_wdata  in  ACC_W  bias value
- i_cfg_delay  in  $clog2(MAX_PIPES+1)  alignment delay D
- i_mac_afresh  in  1  restart accumulation
- i_mac_enable  in  1  accumulate one MAC step
- i_mac_mode  in  $clog2(MODES)  bias-table select
- i_mac_shift  in  2  bias shift code, shift = 8*code
- i_drain_req  in  1  push snapshot
- i_vld  in  1  drain beat valid
- i_last  in  1  last beat of a drain; pops snapshot
- i_dat  in  CH*(SC_W+ACC_W)  per channel {scale, bias}, channel 0 in LSBs
- o_vld  out  1  aligned beat valid
- o_last  out  1  aligned last flag
- o_dat  out  CH*(SC_W+ACC_W)  adjusted data
- o_snap_cnt  out  $clog2(SNAP_DEPTH+1)  queue occupancy
- o_ovf  out  1  sticky snapshot overflow
- o_unf  out  1  sticky snapshot underflow

Behaviour:
- Clock and reset: one clock, aixh_core_clk2x. Reset aixh_core_rstn is synchronous and active-low.
- Reset values:
  - acc_curr = 0, bias table = 0, queue empty.
  - o_vld = 0, o_last = 0, o_dat = 0, o_snap_cnt = 0, o_ovf = 0, o_unf = 0.
  - Reset mid-drain discards everything in flight; no output beat follows reset.
- Bias table:
  - When i_cfg_we, table[i_cfg_addr] is written at the clock edge.
  - A write and a read of the same entry in the same cycle read the old value.
- Accumulator:
  - Priority: afresh, then enable.
  - afresh: acc_curr <= 1.
  - enable: acc_curr <= acc_curr + (table[i_mac_mode] << 8*i_mac_shift), truncated to ACC_W (wraps modulo 2^ACC_W).
  - Otherwise acc_curr holds.
- Snapshot queue (FIFO):
  - i_drain_req pushes the current registered acc_curr, i.e. the value before this cycle's update.
  - Pop is i_vld & i_last.
  - Push and pop in the same cycle are both performed, including when the queue is full.
  - Push when full without pop: snapshot dropped, o_ovf <= 1.
  - A push in the same cycle cannot serve a pop.
- Adjust stage:
  - For i_vld beats, each channel's bias field = i_dat bias + head snapshot (mod 2^ACC_W); the scale field passes unchanged.
  - If the queue is empty at an i_vld beat: snapshot treated as 0, o_unf <= 1, and an i_last pop is ignored.
- Alignment pipe:
  - Valid/last/data shift register of MAX_PIPES stages.
  - Output is taken at tap Deff = clamp(i_cfg_delay, 1, MAX_PIPES); a beat with i_vld at cycle t appears at o_vld at cycle t+Deff.
  - Data stages load only when their incoming valid is 1; o_dat holds the last valid beat.
  - i_cfg_delay is changed only when the pipe is empty. Output across a mid-stream change is unspecified and is not checked.
- Sticky flags: o_ovf and o_unf clear only on reset.
- o_snap_cnt is registered and reflects the queue after the current edge.

Decomposition:
- AIXH_MXC_pkg gains:
  - BIAS_SHIFT_STEP = 8
  - default CH/ACC_W/SC_W constants
  - a packed struct for one {scale, bias} channel
  - a packed struct for accumulator control {afresh, enable, mode, shift, drain_req}
- Sub-module aixh_mxc_snap_fifo: parametrised SNAP_DEPTH×ACC_W queue with pointers, count, and ovf/unf detection; synchronous active-low reset.

Test Plan:
- Basic drain:
  - Stimulus: table[0]=0x100; afresh; 3× enable mode0 shift0; drain_req; D=4; beat i_vld/i_last, ch0 bias=0x10, scale=0x7.
  - Response: o_vld exactly 4 cycles later, ch0 bias=0x311, scale=0x7, o_snap_cnt returns to 0.
- Shift and wrap:
  - Stimulus: ACC_W=48, table[2]=0xFFFF_FFFF_FFFF; afresh; enable mode2 shift1.
  - Response: acc_curr = 0xFFFF_FFFF_FF01 (truncated); drain adds it to bias 0xFF, giving 0x0000 in the low 16 bits with the carry truncated.
- Queue depth:
  - Stimulus: 5 drain_req with acc values 1..5, no pops, SNAP_DEPTH=4.
  - Response: o_snap_cnt=4, o_ovf=1, subsequent 4 last beats use snapshots 1,2,3,4 in order.
- Underflow:
  - Stimulus: i_vld & i_last with empty queue, bias=0x20.
  - Response: output bias 0x20, o_unf=1, o_snap_cnt stays 0.
- Delay clamp:
  - Stimulus: D=0, then D=15 with MAX_PIPES=8, single beat each with the pipe empty.
  - Response: latency 1 then 8 cycles.
- Reset mid-operation:
  - Stimulus: 2 beats in flight, queue cnt=2; assert aixh_core_rstn low 1 cycle.
  - Response: next cycle o_vld=0, o_dat=0, o_snap_cnt=0, flags 0, no late beats.
